alu_operand_loader: RTL

- Front end of the ALU board design. It is the responder side of the switch/strobe operand-entry protocol.
- The operator sets SW[31:0] and then pulses one of three strobe buttons:
  - clk_A latches operand A.
  - clk_B latches operand B.
  - clk_F latches the ALU function code and issues the operation.
- The block synchronises and debounces the three strobes in the single system clock domain. It registers the operands and op code, and emits a one-cycle op_valid handshake to the ALU core.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_operand_loader_if.sv | 32 +++
 rtl/alu_operand_loader_strobe_debounce.sv | 67 ++++++
 rtl/alu_operand_loader.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU board definitions: default widths, function codes and debounce depths.
// Imported by the operand loader, its interface and the strobe debouncer.
package alu_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_OP_W        = 4;
  localparam int DB_CYCLES_SIM   = 4;
  localparam int DB_CYCLES_BOARD = 1_000_000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic a;
    logic b;
    logic f;
  } strobe_set_t;

  function automatic logic issue_ready(input logic a_loaded, input logic b_loaded);
    return a_loaded & b_loaded;
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Switch/strobe operand-entry bus between the operator panel and the operand loader.
// The panel side is the master; the loader is the slave.
interface alu_operand_loader_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);

  logic [DATA_W-1:0] SW;
  logic              clk_A;
  logic              clk_B;
  logic              clk_F;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   ALU_OP;
  logic              op_valid;
  logic              op_err;
  logic              a_loaded;
  logic              b_loaded;

  modport master (
    output SW, clk_A, clk_B, clk_F,
    input  A, B, ALU_OP, op_valid, op_err, a_loaded, b_loaded
  );

  modport slave (
    input  SW, clk_A, clk_B, clk_F,
    output A, B, ALU_OP, op_valid, op_err, a_loaded, b_loaded
  );

endinterface

// File: rtl/alu_operand_loader_strobe_debounce.sv
// One push-button strobe: two-flop synchroniser, stability counter and rising-edge detect.
// The debounced level flips only after DB_CYCLES consecutive synchronised samples disagree with it.
module strobe_debounce
  import alu_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count disagreeing samples, flip on the last one
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = {CNT_W{1'b0}};
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounced level, its one-cycle-delayed copy and the stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand-entry front end: debounces the A/B/F strobes, latches operands and op code from SW,
// and issues a one-cycle op_valid (or op_err when an operand is still missing).
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int DB_CYCLES = DB_CYCLES_SIM
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_operand_loader_if.slave  bus
);

  strobe_set_t       level_s;
  strobe_set_t       rise_s;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              a_ld_q, a_ld_d;
  logic              b_ld_q, b_ld_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  strobe_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.clk_A),
    .level (level_s.a),
    .rise  (rise_s.a)
  );

  strobe_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.clk_B),
    .level (level_s.b),
    .rise  (rise_s.b)
  );

  strobe_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_f (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.clk_F),
    .level (level_s.f),
    .rise  (rise_s.f)
  );

  // Load and issue next-state; the loaded flags already include same-cycle A/B loads
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    a_ld_d  = a_ld_q;
    b_ld_d  = b_ld_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (rise_s.a && level_s.a) begin
      a_d    = bus.SW;
      a_ld_d = 1'b1;
    end else begin
      a_d    = a_q;
    end

    if (rise_s.b && level_s.b) begin
      b_d    = bus.SW;
      b_ld_d = 1'b1;
    end else begin
      b_d    = b_q;
    end

    if (rise_s.f && level_s.f) begin
      op_d = bus.SW[OP_W-1:0];
      if (issue_ready(a_ld_d, b_ld_d)) begin
        valid_d = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end else begin
      op_d = op_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
      op_q    <= {OP_W{1'b0}};
      a_ld_q  <= 1'b0;
      b_ld_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      a_ld_q  <= a_ld_d;
      b_ld_q  <= b_ld_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.ALU_OP   = op_q;
  assign bus.a_loaded = a_ld_q;
  assign bus.b_loaded = b_ld_q;
  assign bus.op_valid = valid_q;
  assign bus.op_err   = err_q;

endmodule
